// File: rtl/sad_best_match.sv
// Sums ROWS partial SADs into one block SAD per candidate and tracks the minimum
// block SAD, with its index, over CANDIDATES candidates; done pulses on each result.
module sad_best_match #(
  parameter int SAD_WIDTH  = 10,
  parameter int ROWS       = 4,
  parameter int CANDIDATES = 16,
  localparam int ACC_WIDTH = SAD_WIDTH + $clog2(ROWS),
  localparam int IDX_WIDTH = (CANDIDATES > 1) ? $clog2(CANDIDATES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sad_valid,
  input  logic [SAD_WIDTH-1:0] sad_in,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] best_sad,
  output logic [IDX_WIDTH-1:0] best_idx
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [IDX_WIDTH-1:0] cand_cnt_q, cand_cnt_d;
  logic [ACC_WIDTH-1:0] min_q, min_d;
  logic [IDX_WIDTH-1:0] min_idx_q, min_idx_d;
  logic                 first_q, first_d;
  logic                 done_q, done_d;
  logic [ACC_WIDTH-1:0] best_sad_q, best_sad_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [ACC_WIDTH-1:0] blk;

  assign blk = acc_q + ACC_WIDTH'(sad_in);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    row_cnt_d  = row_cnt_q;
    cand_cnt_d = cand_cnt_q;
    min_d      = min_q;
    min_idx_d  = min_idx_q;
    first_d    = first_q;
    done_d     = 1'b0;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;

    // FINISH publishes the result even if a new start arrives the same cycle.
    if (state_q == FINISH) begin
      done_d     = 1'b1;
      best_sad_d = min_q;
      best_idx_d = min_idx_q;
      state_d    = IDLE;
    end

    if (start) begin
      state_d    = ACCUM;
      acc_d      = '0;
      row_cnt_d  = '0;
      cand_cnt_d = '0;
      first_d    = 1'b1;
    end else if (state_q == ACCUM && sad_valid) begin
      if (row_cnt_q == ROW_W'(ROWS - 1)) begin
        // Strict less-than keeps the earliest candidate on ties.
        if (first_q || (blk < min_q)) begin
          min_d     = blk;
          min_idx_d = cand_cnt_q;
        end
        first_d    = 1'b0;
        acc_d      = '0;
        row_cnt_d  = '0;
        cand_cnt_d = cand_cnt_q + IDX_WIDTH'(1);
        if (cand_cnt_q == IDX_WIDTH'(CANDIDATES - 1)) begin
          state_d = FINISH;
        end
      end else begin
        acc_d     = blk;
        row_cnt_d = row_cnt_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      row_cnt_q  <= '0;
      cand_cnt_q <= '0;
      min_q      <= '0;
      min_idx_q  <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      row_cnt_q  <= row_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      min_q      <= min_d;
      min_idx_q  <= min_idx_d;
      first_q    <= first_d;
      done_q     <= done_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign busy     = (state_q == ACCUM);
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule
